// File: rtl/bcd_step_counter_if.sv
// Control and result bundle for the single-digit BCD step counter.
// The master side drives the count controls; the slave side is the counter.
interface bcd_step_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr;
  logic [3:0] bcd;
  logic       carry;
  logic       borrow;
  logic       load_err;

  modport master (
    output en, up, load, load_val, clr,
    input  bcd, carry, borrow, load_err
  );

  modport slave (
    input  en, up, load, load_val, clr,
    output bcd, carry, borrow, load_err
  );
endinterface

// File: rtl/bcd_step_counter.sv
// Single-digit BCD up/down counter with prescaler, synchronous load/clear and
// a sticky error state entered on attempted loads of non-BCD values.
// The digit on bcd is always 0-9 so the downstream Gray converter stays valid.
module bcd_step_counter #(
  parameter int TICK_DIV = 1,
  parameter bit WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_step_counter_if.slave   bus
);

  typedef enum logic {RUN, ERR} state_t;

  localparam logic [3:0] PRESC_LAST = 4'(TICK_DIV - 1);

  state_t     state, next_state;
  logic [3:0] bcd_q, next_bcd;
  logic [3:0] presc, next_presc;
  logic       carry_q, next_carry;
  logic       borrow_q, next_borrow;
  logic       bad_load;
  logic       step;

  assign bad_load = bus.load_val > 4'd9;

  // Register all state; reset returns to RUN with a zero digit and no pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      bcd_q    <= 4'd0;
      presc    <= 4'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state    <= next_state;
      bcd_q    <= next_bcd;
      presc    <= next_presc;
      carry_q  <= next_carry;
      borrow_q <= next_borrow;
    end
  end

  // Next-state logic with priority clear, then load, then prescaled count step.
  always_comb begin
    next_state  = state;
    next_bcd    = bcd_q;
    next_presc  = presc;
    next_carry  = 1'b0;
    next_borrow = 1'b0;
    step        = 1'b0;

    if (bus.clr) begin
      next_state = RUN;
      next_bcd   = 4'd0;
      next_presc = 4'd0;
    end else if (bus.load) begin
      if (bad_load) begin
        next_state = ERR;
      end else if (state == RUN) begin
        next_bcd   = bus.load_val;
        next_presc = 4'd0;
      end
    end else if (state == RUN && bus.en) begin
      if (presc == PRESC_LAST) begin
        next_presc = 4'd0;
        step       = 1'b1;
      end else begin
        next_presc = presc + 4'd1;
      end
    end

    if (step) begin
      if (bus.up) begin
        if (bcd_q >= 4'd9) begin
          if (WRAP) begin
            next_bcd   = 4'd0;
            next_carry = 1'b1;
          end else begin
            next_bcd = 4'd9;
          end
        end else begin
          next_bcd = bcd_q + 4'd1;
        end
      end else begin
        if (bcd_q == 4'd0) begin
          if (WRAP) begin
            next_bcd    = 4'd9;
            next_borrow = 1'b1;
          end else begin
            next_bcd = 4'd0;
          end
        end else begin
          next_bcd = bcd_q - 4'd1;
        end
      end
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.load_err = (state == ERR);

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed testbench for bcd_step_counter: three instances cover the wrapping
// divide-by-1, wrapping divide-by-3 and saturating divide-by-1 configurations.
`timescale 1ns/1ps
module tb_bcd_step_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_step_counter_if ifa ();
  bcd_step_counter_if ifb ();
  bcd_step_counter_if ifc ();

  bcd_step_counter #(.TICK_DIV(1), .WRAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  bcd_step_counter #(.TICK_DIV(3), .WRAP(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  bcd_step_counter #(.TICK_DIV(1), .WRAP(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.en = 1'b0; ifa.up = 1'b1; ifa.load = 1'b0; ifa.load_val = 4'd0; ifa.clr = 1'b0;
    ifb.en = 1'b0; ifb.up = 1'b1; ifb.load = 1'b0; ifb.load_val = 4'd0; ifb.clr = 1'b0;
    ifc.en = 1'b0; ifc.up = 1'b1; ifc.load = 1'b0; ifc.load_val = 4'd0; ifc.clr = 1'b0;
    tick();
    tick();
    checks++;
    if ({ifa.bcd, ifa.carry, ifa.borrow, ifa.load_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_a: got %b expected 0000000", {ifa.bcd, ifa.carry, ifa.borrow, ifa.load_err});
    end
    checks++;
    if ({ifb.bcd, ifb.carry, ifb.borrow, ifb.load_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_b: got %b expected 0000000", {ifb.bcd, ifb.carry, ifb.borrow, ifb.load_err});
    end
    checks++;
    if ({ifc.bcd, ifc.carry, ifc.borrow, ifc.load_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_c: got %b expected 0000000", {ifc.bcd, ifc.carry, ifc.borrow, ifc.load_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] exp;
    ifa.en = 1'b1;
    ifa.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = 4'(i % 10);
      checks++;
      if (ifa.bcd !== exp) begin
        failures++;
        $display("FAIL up_bcd[%0d]: got %0d expected %0d", i, ifa.bcd, exp);
      end
      checks++;
      if (ifa.carry !== (exp == 4'd0) || ifa.borrow !== 1'b0) begin
        failures++;
        $display("FAIL up_pulse[%0d]: got carry=%b borrow=%b expected carry=%b borrow=0",
                 i, ifa.carry, ifa.borrow, exp == 4'd0);
      end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    ifa.en = 1'b1;
    ifa.up = 1'b0;
    ifa.load = 1'b1;
    ifa.load_val = 4'd3;
    tick();
    checks++;
    if (ifa.bcd !== 4'd3 || ifa.carry !== 1'b0 || ifa.borrow !== 1'b0) begin
      failures++;
      $display("FAIL load_no_step: got bcd=%0d c=%b b=%b expected bcd=3 c=0 b=0", ifa.bcd, ifa.carry, ifa.borrow);
    end
    ifa.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifa.bcd !== exp_seq[i]) begin
        failures++;
        $display("FAIL down_bcd[%0d]: got %0d expected %0d", i, ifa.bcd, exp_seq[i]);
      end
      checks++;
      if (ifa.borrow !== (exp_seq[i] == 4'd9) || ifa.carry !== 1'b0) begin
        failures++;
        $display("FAIL down_pulse[%0d]: got borrow=%b carry=%b expected borrow=%b carry=0",
                 i, ifa.borrow, ifa.carry, exp_seq[i] == 4'd9);
      end
    end
  endtask

  task automatic test_back_to_back();
    ifa.en = 1'b0;
    ifa.load = 1'b1;
    ifa.load_val = 4'd4;
    tick();
    checks++;
    if (ifa.bcd !== 4'd4) begin
      failures++;
      $display("FAIL b2b_load_first: got %0d expected 4", ifa.bcd);
    end
    ifa.load_val = 4'd6;
    tick();
    checks++;
    if (ifa.bcd !== 4'd6) begin
      failures++;
      $display("FAIL b2b_load_second: got %0d expected 6", ifa.bcd);
    end
    ifa.load = 1'b0;
  endtask

  task automatic test_prescale();
    logic en_pat [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int enabled;
    logic [3:0] exp;
    enabled = 0;
    ifb.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ifb.en = en_pat[i];
      tick();
      if (en_pat[i]) enabled++;
      exp = 4'(enabled / 3);
      checks++;
      if (ifb.bcd !== exp) begin
        failures++;
        $display("FAIL presc_bcd[%0d]: got %0d expected %0d", i, ifb.bcd, exp);
      end
    end
    // Ten enabled cycles leave the prescaler mid-period; a load must restart it.
    ifb.load = 1'b1;
    ifb.load_val = 4'd7;
    tick();
    ifb.load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = (i == 3) ? 4'd8 : 4'd7;
      checks++;
      if (ifb.bcd !== exp) begin
        failures++;
        $display("FAIL presc_after_load[%0d]: got %0d expected %0d", i, ifb.bcd, exp);
      end
    end
    ifb.en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] exp;
    ifc.en = 1'b1;
    ifc.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = (i > 9) ? 4'd9 : 4'(i);
      checks++;
      if (ifc.bcd !== exp || ifc.carry !== 1'b0 || ifc.borrow !== 1'b0) begin
        failures++;
        $display("FAIL sat_up[%0d]: got bcd=%0d c=%b b=%b expected bcd=%0d c=0 b=0",
                 i, ifc.bcd, ifc.carry, ifc.borrow, exp);
      end
    end
    ifc.up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = (i > 9) ? 4'd0 : 4'(9 - i);
      checks++;
      if (ifc.bcd !== exp || ifc.carry !== 1'b0 || ifc.borrow !== 1'b0) begin
        failures++;
        $display("FAIL sat_down[%0d]: got bcd=%0d c=%b b=%b expected bcd=%0d c=0 b=0",
                 i, ifc.bcd, ifc.carry, ifc.borrow, exp);
      end
    end
    ifc.en = 1'b0;
  endtask

  task automatic test_error();
    ifa.en = 1'b0;
    ifa.up = 1'b1;
    ifa.load = 1'b1;
    ifa.load_val = 4'd5;
    tick();
    ifa.load_val = 4'd12;
    tick();
    checks++;
    if (ifa.load_err !== 1'b1 || ifa.bcd !== 4'd5) begin
      failures++;
      $display("FAIL err_enter: got err=%b bcd=%0d expected err=1 bcd=5", ifa.load_err, ifa.bcd);
    end
    ifa.load_val = 4'd2;
    ifa.en = 1'b1;
    tick();
    checks++;
    if (ifa.load_err !== 1'b1 || ifa.bcd !== 4'd5) begin
      failures++;
      $display("FAIL err_ignore_load: got err=%b bcd=%0d expected err=1 bcd=5", ifa.load_err, ifa.bcd);
    end
    ifa.load = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ifa.load_err !== 1'b1 || ifa.bcd !== 4'd5) begin
      failures++;
      $display("FAIL err_frozen: got err=%b bcd=%0d expected err=1 bcd=5", ifa.load_err, ifa.bcd);
    end
    ifa.clr = 1'b1;
    tick();
    checks++;
    if (ifa.load_err !== 1'b0 || ifa.bcd !== 4'd0) begin
      failures++;
      $display("FAIL err_clear: got err=%b bcd=%0d expected err=0 bcd=0", ifa.load_err, ifa.bcd);
    end
    ifa.clr = 1'b0;
    tick();
    tick();
    checks++;
    if (ifa.bcd !== 4'd2) begin
      failures++;
      $display("FAIL err_resume: got %0d expected 2", ifa.bcd);
    end
  endtask

  task automatic test_priority();
    ifa.en = 1'b1;
    ifa.up = 1'b1;
    ifa.load = 1'b1;
    ifa.load_val = 4'd7;
    ifa.clr = 1'b1;
    tick();
    checks++;
    if (ifa.bcd !== 4'd0 || ifa.carry !== 1'b0) begin
      failures++;
      $display("FAIL clr_over_load: got bcd=%0d c=%b expected bcd=0 c=0", ifa.bcd, ifa.carry);
    end
    ifa.clr = 1'b0;
    ifa.load_val = 4'd9;
    tick();
    ifa.load = 1'b0;
    ifa.clr = 1'b1;
    tick();
    checks++;
    if (ifa.bcd !== 4'd0 || ifa.carry !== 1'b0) begin
      failures++;
      $display("FAIL clr_on_wrap: got bcd=%0d c=%b expected bcd=0 c=0", ifa.bcd, ifa.carry);
    end
    ifa.clr = 1'b0;
    ifa.load = 1'b1;
    ifa.load_val = 4'd9;
    tick();
    ifa.load = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ifa.bcd, ifa.carry, ifa.borrow, ifa.load_err} !== 7'd0) begin
      failures++;
      $display("FAIL rst_on_wrap: got %b expected 0000000", {ifa.bcd, ifa.carry, ifa.borrow, ifa.load_err});
    end
    rst_n = 1'b1;
    ifa.en = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count_up();
    test_load_down();
    test_back_to_back();
    test_prescale();
    test_saturate();
    test_error();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
